// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
// Sequences 16-bit register-to-register commands through an external
// combinational ALU datapath. The controller owns an 8 x 16 register file
// (r0 hard-wired to zero) and retires one command every 4 cycles:
//   IDLE -> DECODE -> EXEC -> WB -> IDLE
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_instr[15:0]     [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2,
//                       [3:0] shamt, [8:0] imm9
//   alu_sel/opz/cin     datapath function select, subtract, carry-in
//   alu_i1/alu_i2       datapath operands (zero outside EXEC)
//   alu_o/alu_cout      datapath result and carry-out
//   rsp_valid/data/err  one-cycle retire pulse, result, illegal-op flag
//   carry_flag          carry-out of the last retired ADD/SUB
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SLA, 7 SRA, 8 LDI,
// 9-15 illegal.
module alu_cmd_ctrl #(
  parameter bit SUB_CIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_instr,
  output logic [2:0]  alu_sel,
  output logic        alu_opz,
  output logic        alu_cin,
  output logic [15:0] alu_i1,
  output logic [15:0] alu_i2,
  input  logic [15:0] alu_o,
  input  logic        alu_cout,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        carry_flag
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  typedef enum logic [1:0] {K_ALU, K_LDI, K_ILL} kind_t;

  state_t      state_q;
  kind_t       kind_q, kind_d;
  logic [15:0] instr_q;
  logic [15:0] res_q, res_d;
  logic [15:0] opa_d, opb_d;
  logic        cout_q;
  logic        cmd_ready_q, rsp_valid_q, rsp_err_q, carry_q;
  logic [15:0] rsp_data_q;
  logic [2:0]  alu_sel_q;
  logic        alu_opz_q, alu_cin_q;
  logic [15:0] alu_i1_q, alu_i2_q;
  logic [15:0] rf_q [8];

  // Field extraction from the latched command only; the datapath never
  // sees cmd_instr combinationally.
  logic [3:0] opc, shamt;
  logic [2:0] rd, rs1, rs2;
  logic [8:0] imm9;
  logic       is_arith, is_sub, is_shift;

  assign opc      = instr_q[15:12];
  assign rd       = instr_q[11:9];
  assign rs1      = instr_q[8:6];
  assign rs2      = instr_q[5:3];
  assign shamt    = instr_q[3:0];
  assign imm9     = instr_q[8:0];
  assign is_arith = (opc[3:1] == 3'd0);
  assign is_sub   = (opc == 4'd1);
  assign is_shift = (opc[3:2] == 2'b01);

  always_comb begin
    kind_d = K_ILL;
    if (!opc[3])           kind_d = K_ALU;
    else if (opc == 4'd8)  kind_d = K_LDI;
    opa_d = (rs1 == 3'd0) ? 16'h0 : rf_q[rs1];
    opb_d = is_shift ? {12'h0, shamt} : ((rs2 == 3'd0) ? 16'h0 : rf_q[rs2]);
    res_d = 16'h0;
    case (kind_q)
      K_ALU:   res_d = alu_o;
      K_LDI:   res_d = {{7{imm9[8]}}, imm9};
      default: res_d = 16'h0;
    endcase
  end

  // The alu_* drive registers double as the operand registers: they are
  // loaded at the end of DECODE (so they are live for exactly the EXEC
  // cycle) and cleared at the end of EXEC. The register file is only
  // written in WB, so a command whose rd matches rs1/rs2 always reads the
  // old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= K_ILL;
      instr_q     <= 16'h0;
      res_q       <= 16'h0;
      cout_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0;
      rsp_err_q   <= 1'b0;
      carry_q     <= 1'b0;
      alu_sel_q   <= 3'd0;
      alu_opz_q   <= 1'b0;
      alu_cin_q   <= 1'b0;
      alu_i1_q    <= 16'h0;
      alu_i2_q    <= 16'h0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            instr_q     <= cmd_instr;
            cmd_ready_q <= 1'b0;
            state_q     <= DECODE;
          end
        end
        DECODE: begin
          kind_q <= kind_d;
          if (kind_d == K_ALU) begin
            alu_sel_q <= opc[2:0];
            alu_opz_q <= is_sub;
            alu_cin_q <= is_sub & SUB_CIN;
            alu_i1_q  <= opa_d;
            alu_i2_q  <= opb_d;
          end
          state_q <= EXEC;
        end
        EXEC: begin
          res_q     <= res_d;
          cout_q    <= alu_cout;
          alu_sel_q <= 3'd0;
          alu_opz_q <= 1'b0;
          alu_cin_q <= 1'b0;
          alu_i1_q  <= 16'h0;
          alu_i2_q  <= 16'h0;
          state_q   <= WB;
        end
        WB: begin
          if (kind_q != K_ILL && rd != 3'd0) rf_q[rd] <= res_q;
          if (kind_q == K_ALU && is_arith)   carry_q  <= cout_q;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= res_q;
          rsp_err_q   <= (kind_q == K_ILL);
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign carry_flag = carry_q;
  assign alu_sel    = alu_sel_q;
  assign alu_opz    = alu_opz_q;
  assign alu_cin    = alu_cin_q;
  assign alu_i1     = alu_i1_q;
  assign alu_i2     = alu_i2_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Testbench for alu_cmd_ctrl: a combinational datapath drives alu_o/alu_cout,
// directed and random commands are compared against an architectural model
// of the register file and carry flag.
module tb_alu_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_instr;
  logic [2:0]  alu_sel;
  logic        alu_opz, alu_cin;
  logic [15:0] alu_i1, alu_i2, alu_o;
  logic        alu_cout;
  logic        rsp_valid, rsp_err, carry_flag;
  logic [15:0] rsp_data;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_rf [8];
  logic        m_cf;

  always #5 clk = ~clk;

  alu_cmd_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr), .alu_sel(alu_sel), .alu_opz(alu_opz),
    .alu_cin(alu_cin), .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_o(alu_o),
    .alu_cout(alu_cout), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .carry_flag(carry_flag)
  );

  // External datapath
  logic [16:0] dp_sum;
  always_comb begin
    dp_sum   = {1'b0, alu_i1} + {1'b0, (alu_opz ? ~alu_i2 : alu_i2)} + {16'h0, alu_cin};
    alu_o    = 16'h0;
    alu_cout = 1'b0;
    case (alu_sel)
      3'd0, 3'd1: begin alu_o = dp_sum[15:0]; alu_cout = dp_sum[16]; end
      3'd2:       alu_o = alu_i1 & alu_i2;
      3'd3:       alu_o = alu_i1 | alu_i2;
      3'd4, 3'd6: alu_o = alu_i1 << alu_i2[3:0];
      3'd5:       alu_o = alu_i1 >> alu_i2[3:0];
      default:    alu_o = $signed(alu_i1) >>> alu_i2[3:0];
    endcase
  end

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int op, input int rd, input int a, input int b);
    return {op[3:0], rd[2:0], a[2:0], b[2:0], 3'b000};
  endfunction
  function automatic logic [15:0] enc_s(input int op, input int rd, input int a, input int sh);
    return {op[3:0], rd[2:0], a[2:0], 2'b00, sh[3:0]};
  endfunction
  function automatic logic [15:0] enc_l(input int rd, input int imm);
    return {4'd8, rd[2:0], imm[8:0]};
  endfunction

  // Architectural reference: integer arithmetic on the model register file.
  task automatic model(input logic [15:0] ins, output logic [15:0] d, output logic e);
    int op, rd, sh, a, b, r, sa, im;
    op = int'(ins[15:12]); rd = int'(ins[11:9]); sh = int'(ins[3:0]);
    a = int'(m_rf[ins[8:6]]); b = int'(m_rf[ins[5:3]]);
    e = 1'b0; r = 0;
    case (op)
      0: begin r = a + b; m_cf = (r > 65535); end
      1: begin r = a - b; m_cf = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4, 6: r = a << sh;
      5: r = a >> sh;
      7: begin sa = (a >= 32768) ? a - 65536 : a; r = sa >>> sh; end
      8: begin im = int'(ins[8:0]); if (im >= 256) im -= 512; r = im; end
      default: e = 1'b1;
    endcase
    d = e ? 16'h0 : r[15:0];
    if (!e && rd != 0) m_rf[rd] = d;
  endtask

  // One full command. With hold=1 cmd_valid stays high and cmd_instr is
  // scrambled while the controller is busy.
  task automatic do_cmd(input logic [15:0] ins, input bit hold);
    int op, w;
    logic [2:0]  e_sel;
    logic        e_opz, e_cin, e_e;
    logic [15:0] e_i1, e_i2, e_d;
    op = int'(ins[15:12]);
    cmd_instr = ins;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 8) begin @(posedge clk); #1; w++; end
    chkw("ready_wait", 16'(w), 16'd0);
    if (op <= 7) begin
      e_sel = op[2:0]; e_opz = (op == 1); e_cin = (op == 1);
      e_i1  = m_rf[ins[8:6]];
      e_i2  = (op >= 4) ? {12'h0, ins[3:0]} : m_rf[ins[5:3]];
    end else begin
      e_sel = 3'd0; e_opz = 1'b0; e_cin = 1'b0; e_i1 = 16'h0; e_i2 = 16'h0;
    end
    @(posedge clk); #1;  // DECODE
    if (hold) cmd_instr = 16'($urandom); else cmd_valid = 1'b0;
    chkb("ready_busy", cmd_ready, 1'b0);
    chkw("drv_decode", alu_i1 | alu_i2 | {12'h0, alu_sel, alu_opz | alu_cin}, 16'h0);
    chkb("rsp_decode", rsp_valid, 1'b0);
    @(posedge clk); #1;  // EXEC
    chkw("alu_sel", {13'h0, alu_sel}, {13'h0, e_sel});
    chkb("alu_opz", alu_opz, e_opz);
    chkb("alu_cin", alu_cin, e_cin);
    chkw("alu_i1", alu_i1, e_i1);
    chkw("alu_i2", alu_i2, e_i2);
    chkb("rsp_exec", rsp_valid, 1'b0);
    @(posedge clk); #1;  // WB
    chkw("drv_wb", alu_i1 | alu_i2 | {12'h0, alu_sel, alu_opz | alu_cin}, 16'h0);
    chkb("rsp_wb", rsp_valid, 1'b0);
    @(posedge clk); #1;  // retired
    model(ins, e_d, e_e);
    chkb("rsp_valid", rsp_valid, 1'b1);
    chkw("rsp_data", rsp_data, e_d);
    chkb("rsp_err", rsp_err, e_e);
    chkb("carry_flag", carry_flag, m_cf);
    chkb("ready_ret", cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_instr = 16'h0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_cf = 1'b0;
    #2;
    chkb("rst_ready", cmd_ready, 1'b1);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkw("rst_rsp_data", rsp_data, 16'h0);
    chkb("rst_rsp_err", rsp_err, 1'b0);
    chkb("rst_carry", carry_flag, 1'b0);
    chkw("rst_drv", alu_i1 | alu_i2 | {12'h0, alu_sel, alu_opz | alu_cin}, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // LDI sign extension, ADD carry
    do_cmd(enc_l(1, 'h1FF), 1'b0);
    chkw("ldi_1ff", rsp_data, 16'hFFFF);
    do_cmd(enc_r(0, 2, 1, 1), 1'b0);
    chkw("add_ffff", rsp_data, 16'hFFFE);
    chkb("add_carry", carry_flag, 1'b1);

    // SUB with borrow
    do_cmd(enc_l(3, 5), 1'b0);
    do_cmd(enc_l(4, 7), 1'b0);
    do_cmd(enc_r(1, 5, 3, 4), 1'b0);
    chkw("sub_5_7", rsp_data, 16'hFFFE);
    chkb("sub_carry", carry_flag, 1'b0);

    // Shifts on 0x8001
    do_cmd(enc_l(1, 1), 1'b0);
    do_cmd(enc_l(7, 1), 1'b0);
    do_cmd(enc_s(4, 7, 7, 15), 1'b0);
    do_cmd(enc_r(3, 1, 7, 1), 1'b0);
    chkw("build_8001", rsp_data, 16'h8001);
    do_cmd(enc_s(7, 2, 1, 1), 1'b0);
    chkw("sra1", rsp_data, 16'hC000);
    do_cmd(enc_s(5, 2, 1, 1), 1'b0);
    chkw("srl1", rsp_data, 16'h4000);
    do_cmd(enc_s(4, 2, 1, 15), 1'b0);
    chkw("sll15", rsp_data, 16'h8000);
    do_cmd(enc_s(4, 2, 1, 0), 1'b0);
    chkw("sll0", rsp_data, 16'h8001);

    // Set carry, then illegal opcode targeting r1; r1 and carry must hold
    do_cmd(enc_r(0, 6, 1, 1), 1'b0);
    do_cmd({4'hC, 3'd1, 9'h1AB}, 1'b0);
    chkb("ill_err", rsp_err, 1'b1);
    chkw("ill_data", rsp_data, 16'h0);
    chkb("ill_carry", carry_flag, 1'b1);
    do_cmd(enc_r(3, 3, 1, 0), 1'b0);
    chkw("ill_r1_kept", rsp_data, 16'h8001);

    // Writes to r0 are dropped; rd == rs reads the old value
    do_cmd(enc_l(0, 5), 1'b0);
    do_cmd(enc_r(3, 2, 0, 0), 1'b0);
    chkw("r0_zero", rsp_data, 16'h0);
    do_cmd(enc_r(0, 1, 1, 1), 1'b0);
    chkw("rd_eq_rs", rsp_data, 16'h0002);

    // cmd_valid held high back to back, scrambled instr while busy
    for (int k = 0; k < 6; k++) do_cmd(enc_l(k + 1, 16 * k + 3), 1'b1);
    cmd_valid = 1'b0;

    // Random commands, mixed hold/drop
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'd8;
      else if ($urandom_range(0, 4) != 0) ins[15] = 1'b0;
      do_cmd(ins, 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;

    // Reset during EXEC of ADD r6
    do_cmd(enc_l(6, 'h55), 1'b0);
    cmd_instr = enc_r(0, 6, 2, 2);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chkw("abort_in_exec", {13'h0, alu_sel}, 16'h0);
    #2 rst = 1'b1;
    #1;
    chkb("abort_ready", cmd_ready, 1'b1);
    chkb("abort_rsp", rsp_valid, 1'b0);
    chkw("abort_drv", alu_i1 | alu_i2, 16'h0);
    chkb("abort_carry", carry_flag, 1'b0);
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_cf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chkb("abort_no_rsp", rsp_valid, 1'b0);
    end
    do_cmd(enc_r(3, 7, 6, 0), 1'b0);
    chkw("abort_r6", rsp_data, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
